// File: rtl/nano_pic_if.sv
// CPU-side signal bundle for the nano_pic interrupt controller: interrupt
// sources, the INT_REQ/INT_ACK handshake, the device-select I/O bus and the vector drive.
interface nano_pic_if;
  logic [7:0] irq;
  logic       int_ena;
  logic       int_ack;
  logic       int_req_n;
  logic [3:0] ds;
  logic       rw;
  logic [7:0] bus_d;
  logic [7:0] rd_data;
  logic       rd_oe;
  logic [7:0] vec_out;
  logic       vec_oe;

  modport master (
    output irq, int_ena, int_ack, ds, rw, bus_d,
    input  int_req_n, rd_data, rd_oe, vec_out, vec_oe
  );

  modport slave (
    input  irq, int_ena, int_ack, ds, rw, bus_d,
    output int_req_n, rd_data, rd_oe, vec_out, vec_oe
  );
endinterface

// File: rtl/nano_pic.sv
// Eight-input priority interrupt controller for the nano CPU (irq[0] highest).
// Define PIC_NESTING_EN to let a higher-priority source preempt an in-service handler.
module nano_pic #(
  parameter logic [3:0] DEV_ADDR = 4'h4,
  parameter logic [7:0] VEC_BASE = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  nano_pic_if.slave  bus
);

  localparam logic [3:0] CMD_ADDR = DEV_ADDR + 4'd1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t     state, state_next;
  logic [7:0] s1, s2, prev;
  logic [7:0] pending, mask, isr;
  logic [2:0] req_lvl;

  logic [7:0] edge_det, cand_vec, ack_bit, pending_clr, isr_clr, eoi_bit;
  logic [2:0] cand_lvl, isr_lvl;
  logic       cand_valid, wr_mask, wr_cmd;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) lowest_set = 3'(i);
  endfunction

  assign edge_det = s2 & ~prev;
  assign wr_mask  = (bus.ds == DEV_ADDR) && bus.rw;
  assign wr_cmd   = (bus.ds == CMD_ADDR) && bus.rw;
  assign cand_vec = pending & ~mask;
  assign cand_lvl = lowest_set(cand_vec);
  assign isr_lvl  = lowest_set(isr);

`ifdef PIC_NESTING_EN
  assign cand_valid = (|cand_vec) && ((isr == 8'h00) || (cand_lvl < isr_lvl));
`else
  assign cand_valid = (|cand_vec) && (isr == 8'h00);
`endif

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ack_bit          = 8'h00;
    ack_bit[req_lvl] = bus.int_ack;
    eoi_bit          = 8'h00;
    eoi_bit[isr_lvl] = wr_cmd && bus_d_bit(7) && (|isr);
    isr_clr          = eoi_bit;
    if (wr_cmd && bus_d_bit(5))
      isr_clr[bus.bus_d[2:0]] = 1'b1;
    pending_clr      = ack_bit | ((wr_cmd && bus_d_bit(6)) ? 8'hFF : 8'h00);
  end

  function automatic logic bus_d_bit(input int idx);
    return bus.bus_d[idx];
  endfunction

  // NOTE: state is updated with non-blocking assignments; reset is synchronous and wins over everything, including int_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 8'h00;
      s2      <= 8'h00;
      prev    <= 8'h00;
      pending <= 8'h00;
      mask    <= 8'hFF;
      isr     <= 8'h00;
      req_lvl <= 3'd0;
    end else begin
      s1      <= bus.irq;
      s2      <= s1;
      prev    <= s2;
      // A new edge beats a clear landing in the same clock.
      pending <= (pending & ~pending_clr) | edge_det;
      isr     <= (isr & ~isr_clr) | ack_bit;
      if (wr_mask)
        mask <= bus.bus_d;
      if (cand_valid && !bus.int_ack)
        req_lvl <= cand_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (cand_valid && bus.int_ena && !bus.int_ack) state_next = REQ;
      REQ:  if (!cand_valid || !bus.int_ena || bus.int_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.int_req_n = (state != REQ);
  end

  assign bus.vec_oe  = bus.int_ack;
  assign bus.vec_out = {VEC_BASE[7:5], req_lvl, 2'b00};

  always_comb begin
    bus.rd_oe   = 1'b0;
    bus.rd_data = 8'h00;
    if (!bus.rw && (bus.ds == DEV_ADDR)) begin
      bus.rd_oe   = 1'b1;
      bus.rd_data = pending;
    end else if (!bus.rw && (bus.ds == CMD_ADDR)) begin
      bus.rd_oe   = 1'b1;
      bus.rd_data = isr;
    end
  end

endmodule
